// File: rtl/hist_pkg.sv
// ============================================================================
// Module  : hist_pkg
// Brief   : Shared state encoding and sizing helper for the histogram engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

package hist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        CDF   = 3'd3,
        READY = 3'd4
    } hist_state_t;

    function automatic int calc_levels(input int pixel_w);
        return 1 << pixel_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hist_bin_bank.sv
// ============================================================================
// Module  : hist_bin_bank
// Brief   : Histogram bin registers with one write port and one combinational read port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hist_bin_bank #(
    parameter int ADDR_W  = 8,
    parameter int COUNT_W = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_load,
    input  logic               i_inc,
    input  logic [ADDR_W-1:0]  i_wr_addr,
    input  logic [COUNT_W-1:0] i_load_data,
    input  logic [ADDR_W-1:0]  i_rd_addr,
    output logic [COUNT_W-1:0] o_rd_data
);
    import hist_pkg::*;

    localparam int                 LEVELS  = calc_levels(ADDR_W);
    localparam logic [COUNT_W-1:0] C_MAXCNT = '1;

    logic [COUNT_W-1:0] r_bins [LEVELS];

    // Clear wins over load, load wins over increment; increments stop at full scale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LEVELS; i++) begin
                r_bins[i] <= '0;
            end
        end else if (i_clr) begin
            r_bins[i_wr_addr] <= '0;
        end else if (i_load) begin
            r_bins[i_wr_addr] <= i_load_data;
        end else if (i_inc && (r_bins[i_wr_addr] != C_MAXCNT)) begin
            r_bins[i_wr_addr] <= r_bins[i_wr_addr] + 1'b1;
        end
    end

    assign o_rd_data = r_bins[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/histogram_lut_engine.sv
// ============================================================================
// Module  : histogram_lut_engine
// Brief   : Histogram accumulation, in-place CDF and equalisation LUT lookup.
// Revision: 1.0
// ============================================================================
`default_nettype none

module histogram_lut_engine #(
    parameter int PIXEL_W    = 8,
    parameter int N_PIX_LOG2 = 16,
    parameter int COUNT_W    = N_PIX_LOG2 + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [PIXEL_W-1:0] pixel_in,
    input  logic               pixel_valid,
    output logic               pixel_ready,
    output logic               busy,
    output logic               done,
    input  logic [PIXEL_W-1:0] map_addr,
    output logic [PIXEL_W-1:0] map_data
);
    import hist_pkg::*;

    localparam int                 LEVELS    = calc_levels(PIXEL_W);
    localparam int                 PROD_W    = COUNT_W + PIXEL_W;
    localparam logic [PIXEL_W-1:0] C_LASTIDX = PIXEL_W'(LEVELS - 1);
    localparam logic [COUNT_W-1:0] C_LASTPIX = COUNT_W'((1 << N_PIX_LOG2) - 1);
    localparam logic [PROD_W-1:0]  C_SCALE   = PROD_W'(LEVELS - 1);

    hist_state_t        r_state;
    logic [PIXEL_W-1:0] r_idx;
    logic [COUNT_W-1:0] r_pix_cnt;
    logic [COUNT_W-1:0] r_cdf;
    logic               r_done;
    logic [PIXEL_W-1:0] r_map_data;

    logic               w_clr;
    logic               w_inc;
    logic               w_load;
    logic [PIXEL_W-1:0] w_wr_addr;
    logic [PIXEL_W-1:0] w_rd_addr;
    logic [COUNT_W-1:0] w_rd_data;
    logic [COUNT_W-1:0] w_cdf_new;
    logic [PROD_W-1:0]  w_prod;
    logic [PIXEL_W-1:0] w_lut;

    assign w_clr     = (r_state == CLEAR);
    assign w_inc     = (r_state == ACCUM) && pixel_valid;
    assign w_load    = (r_state == CDF);
    assign w_wr_addr = (r_state == ACCUM) ? pixel_in : r_idx;
    assign w_rd_addr = (r_state == READY) ? map_addr : r_idx;

    // cdf never exceeds N_PIX, so the scaled result always fits in PIXEL_W bits.
    assign w_cdf_new = r_cdf + w_rd_data;
    assign w_prod    = PROD_W'(w_cdf_new) * C_SCALE;
    assign w_lut     = PIXEL_W'(w_prod >> N_PIX_LOG2);

    hist_bin_bank #(
        .ADDR_W  (PIXEL_W),
        .COUNT_W (COUNT_W)
    ) u_bins (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_clr),
        .i_load      (w_load),
        .i_inc       (w_inc),
        .i_wr_addr   (w_wr_addr),
        .i_load_data (COUNT_W'(w_lut)),
        .i_rd_addr   (w_rd_addr),
        .o_rd_data   (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_pix_cnt  <= '0;
            r_cdf      <= '0;
            r_done     <= 1'b0;
            r_map_data <= '0;
        end else begin
            r_done     <= 1'b0;
            r_map_data <= ((r_state == READY) && !start) ? PIXEL_W'(w_rd_data) : '0;
            case (r_state)
                IDLE, READY: begin
                    if (start) begin
                        r_state <= CLEAR;
                        r_idx   <= '0;
                    end
                end
                CLEAR: begin
                    if (r_idx == C_LASTIDX) begin
                        r_state   <= ACCUM;
                        r_idx     <= '0;
                        r_pix_cnt <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ACCUM: begin
                    if (pixel_valid) begin
                        if (r_pix_cnt == C_LASTPIX) begin
                            r_state   <= CDF;
                            r_pix_cnt <= '0;
                            r_cdf     <= '0;
                        end else begin
                            r_pix_cnt <= r_pix_cnt + 1'b1;
                        end
                    end
                end
                CDF: begin
                    r_cdf <= w_cdf_new;
                    if (r_idx == C_LASTIDX) begin
                        r_state <= READY;
                        r_idx   <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign pixel_ready = (r_state == ACCUM);
    assign busy        = (r_state == CLEAR) || (r_state == ACCUM) || (r_state == CDF);
    assign done        = r_done;
    assign map_data    = r_map_data;

endmodule

`default_nettype wire

// File: tb/tb_histogram_lut_engine.sv
// ============================================================================
// Module  : tb_histogram_lut_engine
// Brief   : Directed self-checking bench for histogram_lut_engine (LEVELS=4, N_PIX=8).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_histogram_lut_engine;

    typedef logic [1:0] vec8_t [8];
    typedef logic [1:0] vec4_t [4];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] pixel_in = 2'd0;
    logic       pixel_valid = 1'b0;
    logic       pixel_ready;
    logic       busy;
    logic       done;
    logic [1:0] map_addr = 2'd0;
    logic [1:0] map_data;

    int n_assert = 0;
    int n_fail   = 0;

    histogram_lut_engine #(
        .PIXEL_W    (2),
        .N_PIX_LOG2 (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .busy        (busy),
        .done        (done),
        .map_addr    (map_addr),
        .map_data    (map_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams one image; poke adds start pulses in ACCUM/CDF and stray pixel-3 valids after the last pixel.
    task automatic run_image(input vec8_t img, input bit gaps, input bit poke, input string tag);
        int k       = 0;
        int edges   = 0;
        int gap_cnt = 0;
        bit xfer;
        bit seen      = 1'b0;
        bit ready_bad = 1'b0;
        bit busy_bad  = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (k < 8) begin
                pixel_in    = img[k];
                pixel_valid = !gaps || ($urandom_range(0, 2) != 0);
            end else begin
                pixel_in    = 2'd3;
                pixel_valid = poke;
                if (pixel_ready) ready_bad = 1'b1;
                if (!busy) busy_bad = 1'b1;
            end
            start = (edges == 0) || (poke && ((k == 3) || (k == 8 && busy)));
            if (pixel_ready && !pixel_valid && k < 8) gap_cnt++;
            xfer = pixel_ready && pixel_valid;
            tick();
            edges++;
            if (xfer) k++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start       = 1'b0;
        pixel_valid = 1'b0;
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(edges - 1), 32'(16 + gap_cnt));
        chk({tag, "_ready_after_last"}, 32'(ready_bad), 32'd0);
        chk({tag, "_busy_in_cdf"}, 32'(busy_bad), 32'd0);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_busy_ready"}, 32'(busy), 32'd0);
    endtask

    task automatic check_lut(input vec4_t exp, input string tag);
        for (int a = 0; a < 4; a++) begin
            map_addr = 2'(a);
            tick();
            chk($sformatf("%s_map%0d", tag, a), 32'(map_data), 32'(exp[a]));
        end
    endtask

    initial begin
        vec8_t img1   = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
        vec8_t img2   = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
        vec8_t img1s  = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
        vec4_t lut1   = '{2'd1, 2'd1, 2'd2, 2'd3};
        vec4_t lut2   = '{2'd0, 2'd0, 2'd3, 2'd3};
        vec4_t lut1s  = '{2'd0, 2'd3, 2'd3, 2'd3};
        bit    rb;
        int    w;

        // Reset state
        #12;
        chk("rst_ready", 32'(pixel_ready), 32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_done",  32'(done),        32'd0);
        chk("rst_map",   32'(map_data),    32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Basic image and single-bin image
        run_image(img1, 1'b0, 1'b0, "t1");
        check_lut(lut1, "t1");
        run_image(img2, 1'b0, 1'b0, "t2");
        check_lut(lut2, "t2");

        // Asynchronous reset from READY clears map_data at once
        rst = 1'b1;
        #1;
        chk("rstready_map",  32'(map_data), 32'd0);
        chk("rstready_busy", 32'(busy),     32'd0);
        #2;
        rst = 1'b0;
        tick();

        // Pixels offered in IDLE are refused
        rb          = 1'b0;
        pixel_valid = 1'b1;
        pixel_in    = 2'd3;
        for (int i = 0; i < 5; i++) begin
            if (pixel_ready || busy) rb = 1'b1;
            tick();
        end
        pixel_valid = 1'b0;
        chk("idle_valid_ignored", 32'(rb), 32'd0);

        // Random valid gaps stretch latency by the gap count only
        run_image(img1, 1'b1, 1'b0, "t3");
        check_lut(lut1, "t3");

        // Reset after four pixels, then a clean restart
        start = 1'b1;
        tick();
        start = 1'b0;
        w = 0;
        while (!pixel_ready && w < 20) begin
            tick();
            w++;
        end
        chk("t4_ready_wait", 32'(pixel_ready), 32'd1);
        pixel_valid = 1'b1;
        pixel_in    = 2'd3;
        for (int i = 0; i < 4; i++) tick();
        pixel_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t4_rst_busy",  32'(busy),        32'd0);
        chk("t4_rst_ready", 32'(pixel_ready), 32'd0);
        chk("t4_rst_map",   32'(map_data),    32'd0);
        #2;
        rst = 1'b0;
        tick();
        chk("t4_idle_busy", 32'(busy), 32'd0);
        run_image(img1, 1'b0, 1'b0, "t4");
        check_lut(lut1, "t4");

        // start during ACCUM/CDF ignored, stray valids ignored; start in READY replaces LUT
        run_image(img1, 1'b0, 1'b1, "t5");
        check_lut(lut1, "t5");
        run_image(img1s, 1'b0, 1'b0, "t5b");
        check_lut(lut1s, "t5b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
